// File: rtl/peripheral_timer.sv
// peripheral_timer
//   Timer/counter slave on the peripheral bus. Decodes a 4 KB window and
//   exposes CONFIG, PRESCALE, RELOAD, COUNT and STATUS. It runs a prescaled
//   32-bit down-counter with periodic and one-shot modes, a sticky underflow
//   flag and a level interrupt.
//
// Ports
//   wb_clk_i                  system clock
//   wb_rst_i                  synchronous active-high reset
//   peripheralBus_we          write strobe, single-cycle commit
//   peripheralBus_oe          read strobe, held while busy is high
//   peripheralBus_address     byte address, register offset = address[4:2]
//   peripheralBus_byteSelect  write byte lanes
//   peripheralBus_dataWrite   write data
//   peripheralBus_busy        stall during the first cycle of a read
//   peripheralBus_dataRead    read data, 0 whenever this slave is not driving
//   timer_irq                 level interrupt = flag & irqEnable
//
// Read handshake FSM
//   state   | meaning
//   RD_IDLE | no read in flight; a selected oe raises busy and latches data
//   RD_PEND | latched data on dataRead, busy low, return to idle

module peripheral_timer #(
    parameter logic [23:0] BASE_ADDRESS = 24'h000000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        peripheralBus_we,
    input  logic        peripheralBus_oe,
    input  logic [23:0] peripheralBus_address,
    input  logic [3:0]  peripheralBus_byteSelect,
    input  logic [31:0] peripheralBus_dataWrite,
    output logic        peripheralBus_busy,
    output logic [31:0] peripheralBus_dataRead,
    output logic        timer_irq
);

    typedef enum logic [0:0] {RD_IDLE, RD_PEND} rd_state_t;

    rd_state_t   r_rd_state;
    rd_state_t   w_rd_state_next;
    logic [31:0] r_rd_latch;

    logic        r_enable;
    logic        r_one_shot;
    logic        r_irq_en;
    logic [15:0] r_prescale;
    logic [31:0] r_reload;
    logic [31:0] r_count;
    logic        r_flag;
    logic [15:0] r_pre_count;

    logic        w_sel;
    logic [2:0]  w_offset;
    logic        w_wr;
    logic        w_rd_start;
    logic [31:0] w_mask;
    logic [2:0]  w_cfg_old;
    logic [2:0]  w_cfg_new;
    logic        w_tick;
    logic        w_underflow;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    assign w_sel      = (peripheralBus_address[23:12] == BASE_ADDRESS[23:12]);
    assign w_offset   = peripheralBus_address[4:2];
    assign w_wr       = peripheralBus_we & w_sel;
    assign w_rd_start = peripheralBus_oe & w_sel & (r_rd_state == RD_IDLE);
    assign w_unused   = &{1'b0, peripheralBus_address[11:5], peripheralBus_address[1:0]};

    assign w_mask = {{8{peripheralBus_byteSelect[3]}}, {8{peripheralBus_byteSelect[2]}},
                     {8{peripheralBus_byteSelect[1]}}, {8{peripheralBus_byteSelect[0]}}};

    assign w_cfg_old = {r_irq_en, r_one_shot, r_enable};
    assign w_cfg_new = (w_cfg_old & ~w_mask[2:0]) | (peripheralBus_dataWrite[2:0] & w_mask[2:0]);

    // >= rather than == so that lowering PRESCALE below the running count
    // ticks immediately instead of waiting for a 16-bit wrap.
    assign w_tick      = r_enable & (r_pre_count >= r_prescale);
    assign w_underflow = w_tick & (r_count == 32'd0);

    assign timer_irq = r_flag & r_irq_en;

    // Timer and register file. Bus writes come after the tick logic so a
    // write to the same register in the same cycle takes precedence.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_enable    <= 1'b0;
            r_one_shot  <= 1'b0;
            r_irq_en    <= 1'b0;
            r_prescale  <= '0;
            r_reload    <= '0;
            r_count     <= '0;
            r_flag      <= 1'b0;
            r_pre_count <= '0;
        end else begin
            if (!r_enable || w_tick) begin
                r_pre_count <= '0;
            end else begin
                r_pre_count <= r_pre_count + 16'd1;
            end

            if (w_tick) begin
                if (r_count != 32'd0) begin
                    r_count <= r_count - 32'd1;
                end else begin
                    r_flag <= 1'b1;
                    if (r_one_shot) begin
                        r_enable <= 1'b0;
                    end else begin
                        r_count <= r_reload;
                    end
                end
            end

            if (w_wr) begin
                case (w_offset)
                    3'd0: begin
                        {r_irq_en, r_one_shot, r_enable} <= w_cfg_new;
                        if (w_cfg_new[0] && !r_enable) begin
                            r_pre_count <= '0;
                        end
                    end
                    3'd1: r_prescale <= (r_prescale & ~w_mask[15:0])
                                      | (peripheralBus_dataWrite[15:0] & w_mask[15:0]);
                    3'd2: r_reload <= (r_reload & ~w_mask) | (peripheralBus_dataWrite & w_mask);
                    3'd3: r_count  <= (r_count & ~w_mask) | (peripheralBus_dataWrite & w_mask);
                    3'd4: begin
                        // A simultaneous underflow keeps the flag set.
                        if (peripheralBus_byteSelect[0] && peripheralBus_dataWrite[0] && !w_underflow) begin
                            r_flag <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (w_offset)
            3'd0:    w_rd_mux = {29'd0, r_irq_en, r_one_shot, r_enable};
            3'd1:    w_rd_mux = {16'd0, r_prescale};
            3'd2:    w_rd_mux = r_reload;
            3'd3:    w_rd_mux = r_count;
            3'd4:    w_rd_mux = {31'd0, r_flag};
            default: w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rd_state <= RD_IDLE;
            r_rd_latch <= '0;
        end else begin
            r_rd_state <= w_rd_state_next;
            if (w_rd_start) begin
                r_rd_latch <= w_rd_mux;
            end
        end
    end

    always_comb begin
        w_rd_state_next = RD_IDLE;
        case (r_rd_state)
            RD_IDLE: w_rd_state_next = w_rd_start ? RD_PEND : RD_IDLE;
            RD_PEND: w_rd_state_next = RD_IDLE;
            default: w_rd_state_next = RD_IDLE;
        endcase
    end

    // An early oe drop in RD_PEND drives nothing; the FSM still returns to idle.
    always_comb begin
        peripheralBus_busy     = 1'b0;
        peripheralBus_dataRead = 32'd0;
        case (r_rd_state)
            RD_IDLE: peripheralBus_busy = w_rd_start;
            RD_PEND: if (peripheralBus_oe) peripheralBus_dataRead = r_rd_latch;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_peripheral_timer.sv
module tb_peripheral_timer;

    localparam logic [23:0] A_CONFIG   = 24'h000000;
    localparam logic [23:0] A_PRESCALE = 24'h000004;
    localparam logic [23:0] A_RELOAD   = 24'h000008;
    localparam logic [23:0] A_COUNT    = 24'h00000C;
    localparam logic [23:0] A_STATUS   = 24'h000010;

    logic        clk;
    logic        rst;
    logic        we;
    logic        oe;
    logic [23:0] addr;
    logic [3:0]  bs;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] rdata;
    logic        irq;

    int n_assert;
    int n_fail;

    peripheral_timer #(.BASE_ADDRESS(24'h000000)) dut (
        .wb_clk_i                 (clk),
        .wb_rst_i                 (rst),
        .peripheralBus_we         (we),
        .peripheralBus_oe         (oe),
        .peripheralBus_address    (addr),
        .peripheralBus_byteSelect (bs),
        .peripheralBus_dataWrite  (wdata),
        .peripheralBus_busy       (busy),
        .peripheralBus_dataRead   (rdata),
        .timer_irq                (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [23:0] addr;
        logic [3:0]  bs;
        logic [31:0] data;
        logic        exp_busy;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drives at a negedge; the write commits on the following posedge.
    task automatic bus_write(input logic [23:0] a, input logic [3:0] b, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; bs = b; wdata = d;
        #1 chk("wr_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input string nm, input logic [23:0] a, input logic exp_busy,
                            input logic [31:0] exp_d);
        @(negedge clk);
        oe = 1'b1; addr = a;
        #1;
        chk({nm, "_busy1"}, {31'd0, busy}, {31'd0, exp_busy});
        chk({nm, "_rd1"}, rdata, 32'd0);
        @(negedge clk);
        #1;
        chk({nm, "_busy2"}, {31'd0, busy}, 32'd0);
        chk({nm, "_data"}, rdata, exp_d);
        @(negedge clk);
        oe = 1'b0;
        #1 chk({nm, "_rd_idle"}, rdata, 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1; we = 1'b0; oe = 1'b0; addr = '0; bs = '0; wdata = '0;

        vecs.push_back('{"rst_config",   1'b0, A_CONFIG,     4'h0, 32'h0,        1'b1, 32'h00000000});
        vecs.push_back('{"rst_status",   1'b0, A_STATUS,     4'h0, 32'h0,        1'b1, 32'h00000000});
        vecs.push_back('{"rst_count",    1'b0, A_COUNT,      4'h0, 32'h0,        1'b1, 32'h00000000});
        vecs.push_back('{"w_reload0",    1'b1, A_RELOAD,     4'hF, 32'h0,        1'b0, 32'h0});
        vecs.push_back('{"w_reload_bs",  1'b1, A_RELOAD,     4'h5, 32'hDEADBEEF, 1'b0, 32'h0});
        vecs.push_back('{"reload_bs",    1'b0, A_RELOAD,     4'h0, 32'h0,        1'b1, 32'h00AD00EF});
        vecs.push_back('{"w_pre_all",    1'b1, A_PRESCALE,   4'hF, 32'hFFFFFFFF, 1'b0, 32'h0});
        vecs.push_back('{"pre_16b",      1'b0, A_PRESCALE,   4'h0, 32'h0,        1'b1, 32'h0000FFFF});
        vecs.push_back('{"w_cfg_hi",     1'b1, A_CONFIG,     4'hF, 32'hFFFFFFF8, 1'b0, 32'h0});
        vecs.push_back('{"cfg_hi_zero",  1'b0, A_CONFIG,     4'h0, 32'h0,        1'b1, 32'h00000000});
        vecs.push_back('{"w_count_hi",   1'b1, A_COUNT,      4'hC, 32'h12345678, 1'b0, 32'h0});
        vecs.push_back('{"count_hi",     1'b0, A_COUNT,      4'h0, 32'h0,        1'b1, 32'h12340000});
        vecs.push_back('{"w_outwin",     1'b1, 24'h001008,   4'hF, 32'h11111111, 1'b0, 32'h0});
        vecs.push_back('{"reload_kept",  1'b0, A_RELOAD,     4'h0, 32'h0,        1'b1, 32'h00AD00EF});
        vecs.push_back('{"w_unmapped",   1'b1, 24'h000018,   4'hF, 32'hFFFFFFFF, 1'b0, 32'h0});
        vecs.push_back('{"rd_unmapped",  1'b0, 24'h000018,   4'h0, 32'h0,        1'b1, 32'h00000000});
        vecs.push_back('{"rd_outwin",    1'b0, 24'h001008,   4'h0, 32'h0,        1'b0, 32'h00000000});
        vecs.push_back('{"rd_off14",     1'b0, 24'h000014,   4'h0, 32'h0,        1'b1, 32'h00000000});
        vecs.push_back('{"rd_lowbits",   1'b0, 24'h00000B,   4'h0, 32'h0,        1'b1, 32'h00AD00EF});
        vecs.push_back('{"w_pre_lane1",  1'b1, A_PRESCALE,   4'h2, 32'h0000AB00, 1'b0, 32'h0});
        vecs.push_back('{"pre_lane1",    1'b0, A_PRESCALE,   4'h0, 32'h0,        1'b1, 32'h0000ABFF});
        vecs.push_back('{"cfg_still0",   1'b0, A_CONFIG,     4'h0, 32'h0,        1'b1, 32'h00000000});

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].bs, vecs[i].data);
            else bus_read(vecs[i].name, vecs[i].addr, vecs[i].exp_busy, vecs[i].exp_rd);
        end

        // Periodic: 8-clock period, first underflow 8 clocks after enable.
        bus_write(A_PRESCALE, 4'hF, 32'd1);
        bus_write(A_RELOAD,   4'hF, 32'd3);
        bus_write(A_COUNT,    4'hF, 32'd3);
        bus_write(A_CONFIG,   4'hF, 32'h5);
        #1 chk("per_irq_c0", {31'd0, irq}, 32'd0);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk); #1;
            chk("per_irq_wait1", {31'd0, irq}, 32'd0);
        end
        @(negedge clk); #1;
        chk("per_irq_c8", {31'd0, irq}, 32'd1);
        bus_write(A_STATUS, 4'h1, 32'h1);
        #1 chk("per_irq_clr", {31'd0, irq}, 32'd0);
        for (int i = 11; i <= 15; i++) begin
            @(negedge clk); #1;
            chk("per_irq_wait2", {31'd0, irq}, 32'd0);
        end
        @(negedge clk); #1;
        chk("per_irq_c16", {31'd0, irq}, 32'd1);
        bus_read("per_reload", A_COUNT, 1'b1, 32'd3);

        // W1C colliding with an underflow every clock.
        bus_write(A_CONFIG, 4'hF, 32'h0);
        bus_write(A_STATUS, 4'hF, 32'h1);
        bus_read("w1c_pre", A_STATUS, 1'b1, 32'd0);
        bus_write(A_PRESCALE, 4'hF, 32'd0);
        bus_write(A_RELOAD,   4'hF, 32'd0);
        bus_write(A_COUNT,    4'hF, 32'd0);
        bus_write(A_CONFIG,   4'hF, 32'h5);
        #1 chk("w1c_irq_c0", {31'd0, irq}, 32'd0);
        @(negedge clk); #1;
        chk("w1c_irq_c1", {31'd0, irq}, 32'd1);
        bus_write(A_STATUS, 4'hF, 32'h1);
        #1 chk("w1c_collide_irq", {31'd0, irq}, 32'd1);
        bus_read("w1c_collide", A_STATUS, 1'b1, 32'd1);
        bus_write(A_CONFIG, 4'hF, 32'h4);
        bus_write(A_STATUS, 4'hF, 32'h1);
        #1 chk("w1c_quiet_irq", {31'd0, irq}, 32'd0);
        bus_read("w1c_quiet", A_STATUS, 1'b1, 32'd0);

        // One-shot: underflow on the third tick, then self-disable.
        bus_write(A_COUNT,  4'hF, 32'd2);
        bus_write(A_CONFIG, 4'hF, 32'h3);
        bus_read("os_early", A_STATUS, 1'b1, 32'd0);
        bus_read("os_flag", A_STATUS, 1'b1, 32'd1);
        bus_read("os_cfg", A_CONFIG, 1'b1, 32'h2);
        bus_read("os_count", A_COUNT, 1'b1, 32'd0);
        repeat (10) @(negedge clk);
        bus_write(A_STATUS, 4'h1, 32'h1);
        repeat (10) @(negedge clk);
        bus_read("os_noevent", A_STATUS, 1'b1, 32'd0);
        bus_read("os_count2", A_COUNT, 1'b1, 32'd0);

        // Masking, then reset mid-count and mid-read.
        bus_write(A_RELOAD, 4'hF, 32'd100);
        bus_write(A_COUNT,  4'hF, 32'd0);
        bus_write(A_CONFIG, 4'hF, 32'h5);
        @(negedge clk); #1;
        chk("rs_irq_pre", {31'd0, irq}, 32'd1);
        bus_write(A_CONFIG, 4'hF, 32'h1);
        #1 chk("mask_irq", {31'd0, irq}, 32'd0);
        bus_read("mask_flag", A_STATUS, 1'b1, 32'd1);
        bus_write(A_CONFIG, 4'hF, 32'h5);
        #1 chk("unmask_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        oe = 1'b1; addr = A_COUNT; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; oe = 1'b0;
        #1;
        chk("rs_busy", {31'd0, busy}, 32'd0);
        chk("rs_rdata", rdata, 32'd0);
        chk("rs_irq", {31'd0, irq}, 32'd0);
        bus_read("rs_count", A_COUNT, 1'b1, 32'd0);
        bus_read("rs_cfg", A_CONFIG, 1'b1, 32'd0);
        bus_read("rs_reload", A_RELOAD, 1'b1, 32'd0);
        repeat (5) @(negedge clk);
        #1 chk("rs_irq_late", {31'd0, irq}, 32'd0);
        bus_read("rs_count2", A_COUNT, 1'b1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
